vp_mask_pipe: RTL and testbench

Parametrised, pipelined precision-mask unit for the variable-precision approximate FP multiplier. It holds a per-channel precision/mode configuration and generates a mantissa mask from it; the mask replaces the fixed 11-bit, 4-bit-control mask. Incoming mantissa operand pairs are masked through a 2-stage valid/ready pipeline. The masked operands feed the mantissa multiplier array.

---
 rtl/vp_mask_pkg.sv | 21 ++
 rtl/vp_mask_gen.sv | 26 ++
 rtl/vp_mask_pipe.sv | 130 +++++++++++++
 tb/tb_vp_mask_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_mask_pkg.sv
// Shared defaults, derived-width helpers and the compensation mode type
// for the variable-precision mantissa mask pipeline.
package vp_mask_pkg;

  localparam int MANT_W_DEF   = 11;
  localparam int KEEP_MIN_DEF = 4;

  typedef enum logic {
    MODE_TRUNC = 1'b0,
    MODE_COMP  = 1'b1
  } mode_t;

  function automatic int pmax_of(input int mant_w, input int keep_min);
    return mant_w - keep_min;
  endfunction

  function automatic int prec_w_of(input int mant_w, input int keep_min);
    return $clog2(mant_w - keep_min + 1);
  endfunction

endpackage

// File: rtl/vp_mask_gen.sv
// Combinational mask generator: clears the p LSBs and, in compensate mode,
// supplies the midpoint bit just below the lowest kept bit.
module vp_mask_gen
  import vp_mask_pkg::*;
#(
  parameter  int MANT_W   = MANT_W_DEF,
  parameter  int KEEP_MIN = KEEP_MIN_DEF,
  localparam int PREC_W   = prec_w_of(MANT_W, KEEP_MIN)
) (
  input  logic [PREC_W-1:0] p,
  input  logic              mode,
  output logic [MANT_W-1:0] mask,
  output logic [MANT_W-1:0] comp_bit
);

  // The KEEP_MIN MSBs stay set even if p were ever out of range.
  always_comb begin
    mask     = '0;
    comp_bit = '0;
    for (int i = 0; i < MANT_W; i++) begin
      mask[i]     = (i >= int'(p)) || (i >= MANT_W - KEEP_MIN);
      comp_bit[i] = (mode == MODE_COMP) && (p != '0) && (i == int'(p) - 1);
    end
  end

endmodule

// File: rtl/vp_mask_pipe.sv
// Per-channel precision config plus a 2-stage valid/ready pipeline that
// masks mantissa operand pairs before the multiplier array.
module vp_mask_pipe
  import vp_mask_pkg::*;
#(
  parameter  int MANT_W   = MANT_W_DEF,
  parameter  int KEEP_MIN = KEEP_MIN_DEF,
  parameter  int NUM_CH   = 4,
  localparam int PMAX     = pmax_of(MANT_W, KEEP_MIN),
  localparam int PREC_W   = prec_w_of(MANT_W, KEEP_MIN),
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [PREC_W:0]   cfg_prec,
  input  logic              cfg_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [MANT_W-1:0] in_a,
  input  logic [MANT_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [MANT_W-1:0] out_a,
  output logic [MANT_W-1:0] out_b,
  output logic [MANT_W-1:0] out_mask
);

  localparam logic [PREC_W:0]   PMAX_CFG = PMAX[PREC_W:0];
  localparam logic [PREC_W-1:0] PMAX_P   = PMAX[PREC_W-1:0];

  logic [PREC_W-1:0] prec_q [NUM_CH];
  mode_t             mode_q [NUM_CH];

  logic [PREC_W-1:0] cfg_prec_sat;
  logic              cfg_ok;
  logic              rd_ok;
  logic [PREC_W-1:0] rd_prec;
  mode_t             rd_mode;

  logic              s1_valid;
  logic [CH_W-1:0]   s1_ch;
  logic [MANT_W-1:0] s1_a;
  logic [MANT_W-1:0] s1_b;
  logic [PREC_W-1:0] s1_prec;
  mode_t             s1_mode;
  logic [MANT_W-1:0] s1_mask;
  logic [MANT_W-1:0] s1_comp;

  logic              s2_load;
  logic              s1_adv;
  logic              accept;

  assign cfg_prec_sat = (cfg_prec > PMAX_CFG) ? PMAX_P : cfg_prec[PREC_W-1:0];
  assign cfg_ok       = 32'(cfg_ch) < NUM_CH;
  assign rd_ok        = 32'(in_ch) < NUM_CH;
  assign rd_prec      = rd_ok ? prec_q[in_ch] : '0;
  assign rd_mode      = rd_ok ? mode_q[in_ch] : MODE_TRUNC;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

  // Precision is stored already saturated so stage 1 never sees p > PMAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prec_q[i] <= '0;
        mode_q[i] <= MODE_TRUNC;
      end
    end else if (cfg_we && cfg_ok) begin
      prec_q[cfg_ch] <= cfg_prec_sat;
      mode_q[cfg_ch] <= mode_t'(cfg_mode);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_prec  <= '0;
      s1_mode  <= MODE_TRUNC;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_ch    <= in_ch;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_prec  <= rd_prec;
      s1_mode  <= rd_mode;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  vp_mask_gen #(
    .MANT_W   (MANT_W),
    .KEEP_MIN (KEEP_MIN)
  ) u_mask_gen (
    .p        (s1_prec),
    .mode     (s1_mode),
    .mask     (s1_mask),
    .comp_bit (s1_comp)
  );

  // Output data only moves when stage 1 hands over, so stalls hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_mask  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_ch   <= s1_ch;
        out_a    <= (s1_a & s1_mask) | s1_comp;
        out_b    <= (s1_b & s1_mask) | s1_comp;
        out_mask <= s1_mask;
      end
    end
  end

endmodule

// File: tb/tb_vp_mask_pipe.sv
// Self-checking bench for vp_mask_pipe: directed scenarios plus a randomized
// run scored against a queue-based reference model.
module tb_vp_mask_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [3:0]  cfg_prec = '0;
  logic        cfg_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_ch = '0;
  logic [10:0] in_a = '0;
  logic [10:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_ch;
  logic [10:0] out_a;
  logic [10:0] out_b;
  logic [10:0] out_mask;

  vp_mask_pipe #(.MANT_W(11), .KEEP_MIN(4), .NUM_CH(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_prec(cfg_prec), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_a(out_a), .out_b(out_b), .out_mask(out_mask)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_prec [4] = '{default: 0};
  logic m_mode [4] = '{default: 1'b0};
  logic [34:0] exp_q [$];
  logic [34:0] obs_q [$];

  function automatic logic [10:0] ref_mask(input int p);
    return 11'((2047 >> p) << p);
  endfunction

  function automatic logic [10:0] ref_apply(input logic [10:0] x, input int p, input logic mode);
    logic [10:0] r;
    r = x & ref_mask(p);
    if (mode && p > 0) r = r | 11'(1 << (p - 1));
    return r;
  endfunction

  // Handshakes are observed mid-cycle, where they decide the next rising edge.
  always @(negedge clk) begin
    int p;
    logic md;
    if (!rst) begin
      if (in_valid && in_ready) begin
        p  = m_prec[in_ch];
        md = m_mode[in_ch];
        exp_q.push_back({in_ch, ref_apply(in_a, p, md), ref_apply(in_b, p, md), ref_mask(p)});
      end
      if (out_valid && out_ready) obs_q.push_back({out_ch, out_a, out_b, out_mask});
      if (cfg_we) begin
        m_prec[cfg_ch] = (cfg_prec > 4'd7) ? 7 : int'(cfg_prec);
        m_mode[cfg_ch] = cfg_mode;
      end
    end
  end

  always @(posedge rst) begin
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      m_prec[i] = 0;
      m_mode[i] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [10:0] a, input logic [10:0] b);
    int n = 0;
    in_valid = 1'b1; in_ch = ch; in_a = a; in_b = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [3:0] p, input logic mode);
    cfg_we = 1'b1; cfg_ch = ch; cfg_prec = p; cfg_mode = mode;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    n_cmp++; if ({out_ch, out_a, out_b, out_mask} !== 35'd0) begin n_bad++;
      $display("[TB] FAIL reset_out_data: got %h required 0", {out_ch, out_a, out_b, out_mask}); end
    rst = 1'b0;
    tick();
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++;
      $display("[TB] FAIL reset_release: got valid/ready %b required 01", {out_valid, in_ready}); end
  endtask

  task automatic test_passthrough();
    send(2'd0, 11'h7FF, 11'h123);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL latency_early: out_valid %b required 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL latency_2: out_valid %b required 1", out_valid); end
    n_cmp++; if ({out_ch, out_a, out_b, out_mask} !== {2'd0, 11'h7FF, 11'h123, 11'h7FF}) begin n_bad++;
      $display("[TB] FAIL passthrough: got ch %0d a %h b %h m %h required 0 7ff 123 7ff", out_ch, out_a, out_b, out_mask); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL passthrough_dup: out_valid %b required 0", out_valid); end
  endtask

  task automatic test_truncate();
    cfg_write(2'd1, 4'd3, 1'b0);
    send(2'd1, 11'h7FF, 11'h555);
    tick();
    n_cmp++; if ({out_valid, out_ch, out_a, out_b, out_mask} !== {1'b1, 2'd1, 11'h7F8, 11'h550, 11'h7F8}) begin n_bad++;
      $display("[TB] FAIL truncate_p3: got v %b ch %0d a %h b %h m %h required 1 1 7f8 550 7f8", out_valid, out_ch, out_a, out_b, out_mask); end
    tick();
  endtask

  task automatic test_compensate();
    cfg_write(2'd1, 4'd3, 1'b1);
    send(2'd1, 11'h7FF, 11'h400);
    tick();
    n_cmp++; if ({out_valid, out_ch, out_a, out_b, out_mask} !== {1'b1, 2'd1, 11'h7FC, 11'h404, 11'h7F8}) begin n_bad++;
      $display("[TB] FAIL compensate_p3: got v %b a %h b %h m %h required 1 7fc 404 7f8", out_valid, out_a, out_b, out_mask); end
    tick();
    cfg_write(2'd1, 4'd12, 1'b0);
    send(2'd1, 11'h7FF, 11'h7FF);
    tick();
    n_cmp++; if ({out_valid, out_a, out_b, out_mask} !== {1'b1, 11'h780, 11'h780, 11'h780}) begin n_bad++;
      $display("[TB] FAIL saturate_p12: got v %b a %h b %h m %h required 1 780 780 780", out_valid, out_a, out_b, out_mask); end
    tick();
  endtask

  task automatic test_stall();
    logic [35:0] exp0, exp1, exp2;
    exp0 = {1'b1, 2'd1, 11'h780, 11'h080, 11'h780};
    exp1 = {1'b1, 2'd3, 11'h155, 11'h2AA, 11'h7FF};
    exp2 = {1'b1, 2'd0, 11'h0FF, 11'h7FF, 11'h7FF};
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 2'd1; in_a = 11'h7AB; in_b = 11'h0F1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_accept0: in_ready %b required 1", in_ready); end
    tick();
    in_ch = 2'd3; in_a = 11'h155; in_b = 11'h2AA;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_accept1: in_ready %b required 1", in_ready); end
    tick();
    in_ch = 2'd0; in_a = 11'h0FF; in_b = 11'h7FF;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_full: in_ready %b required 0", in_ready); end
      n_cmp++; if ({out_valid, out_ch, out_a, out_b, out_mask} !== exp0) begin n_bad++;
        $display("[TB] FAIL stall_hold: got %h required %h", {out_valid, out_ch, out_a, out_b, out_mask}, exp0); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_release: in_ready %b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_ch, out_a, out_b, out_mask} !== exp1) begin n_bad++;
      $display("[TB] FAIL stall_drain1: got %h required %h", {out_valid, out_ch, out_a, out_b, out_mask}, exp1); end
    tick();
    n_cmp++; if ({out_valid, out_ch, out_a, out_b, out_mask} !== exp2) begin n_bad++;
      $display("[TB] FAIL stall_drain2: got %h required %h", {out_valid, out_ch, out_a, out_b, out_mask}, exp2); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_empty: out_valid %b required 0", out_valid); end
  endtask

  task automatic test_same_cycle_cfg();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_prec = 4'd5; cfg_mode = 1'b0;
    in_valid = 1'b1; in_ch = 2'd2; in_a = 11'h7FF; in_b = 11'h7FF;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_a, out_mask} !== {1'b1, 11'h7FF, 11'h7FF}) begin n_bad++;
      $display("[TB] FAIL cfg_same_cycle_old: got v %b a %h m %h required 1 7ff 7ff", out_valid, out_a, out_mask); end
    tick();
    n_cmp++; if ({out_valid, out_a, out_mask} !== {1'b1, 11'h7E0, 11'h7E0}) begin n_bad++;
      $display("[TB] FAIL cfg_same_cycle_new: got v %b a %h m %h required 1 7e0 7e0", out_valid, out_a, out_mask); end
    tick();
  endtask

  task automatic test_reset_midflight();
    in_valid = 1'b1; in_ch = 2'd1; in_a = 11'h7FF; in_b = 11'h7FF;
    tick();
    in_ch = 2'd2;
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b11) begin n_bad++;
      $display("[TB] FAIL midflight_full: got valid/ready %b required 11", {out_valid, in_ready}); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({out_valid, in_ready, out_mask} !== {1'b0, 1'b1, 11'h000}) begin n_bad++;
      $display("[TB] FAIL midflight_reset: got v %b r %b m %h required 0 1 000", out_valid, in_ready, out_mask); end
    tick();
    rst = 1'b0;
    repeat (2) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midflight_ghost: out_valid %b required 0", out_valid); end
    send(2'd2, 11'h7FF, 11'h7FF);
    tick();
    n_cmp++; if ({out_valid, out_ch, out_a, out_b, out_mask} !== {1'b1, 2'd2, 11'h7FF, 11'h7FF, 11'h7FF}) begin n_bad++;
      $display("[TB] FAIL midflight_cfg_cleared: got v %b a %h m %h required 1 7ff 7ff", out_valid, out_a, out_mask); end
    tick();
  endtask

  task automatic test_random();
    logic        stall;
    logic [34:0] snap, e, o;
    exp_q.delete();
    obs_q.delete();
    for (int c = 0; c < 410; c++) begin
      if (c < 400) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_ch     = 2'($urandom);
        in_a      = 11'($urandom);
        in_b      = 11'($urandom);
        out_ready = ($urandom_range(0, 9) < 6);
        cfg_we    = ($urandom_range(0, 9) == 0);
        cfg_ch    = 2'($urandom);
        cfg_prec  = 4'($urandom);
        cfg_mode  = 1'($urandom);
      end else begin
        in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
      end
      #1;
      stall = out_valid && !out_ready;
      snap  = {out_ch, out_a, out_b, out_mask};
      tick();
      if (stall) begin
        n_cmp++; if ({out_valid, out_ch, out_a, out_b, out_mask} !== {1'b1, snap}) begin n_bad++;
          $display("[TB] FAIL rand_stall_hold: got %h required %h", {out_valid, out_ch, out_a, out_b, out_mask}, {1'b1, snap}); end
      end
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("[TB] FAIL rand_extra_output: got %h with nothing expected", o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin n_bad++; $display("[TB] FAIL rand_output: got %h required %h", o, e); end
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++;
      $display("[TB] FAIL rand_lost: %0d outputs missing, required 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_truncate();
    test_compensate();
    test_stall();
    test_same_cycle_cfg();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
